// File: rtl/parity_check_sched.sv
// Round-robin scheduler sharing one external parity checker among NCH channels.
// Optional sticky per-channel error flags are enabled with `define PARCTL_STICKY_ERR_EN.
module parity_check_sched #(
  parameter int NCH = 4,
  parameter int DW  = 3,
  parameter int CW  = 8,
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NCH-1:0]    req_valid,
  input  logic [NCH*DW-1:0] req_data,
  output logic [NCH-1:0]    req_ready,
  input  logic [NCH-1:0]    mode_cfg,
  output logic              chk_valid,
  output logic [DW-1:0]     chk_data,
  output logic              chk_mode,
  input  logic              chk_parity_ok,
  output logic              rsp_valid,
  output logic [CHW-1:0]    rsp_chan,
  output logic              rsp_ok,
  input  logic [CHW-1:0]    cnt_sel,
  input  logic              cnt_clr,
  output logic [CW-1:0]     err_cnt,
`ifdef PARCTL_STICKY_ERR_EN
  output logic [NCH-1:0]    err_flag,
  output logic              err_irq,
`endif
  output logic              idle
);

  typedef enum logic [1:0] {RUN, DRAIN, HALT} stateT;

  stateT          state_q, state_d;
  logic [CHW-1:0] rrPtr_q;
  logic           lastVld_q;
  logic           chkValid_q;
  logic [DW-1:0]  chkData_q;
  logic           chkMode_q;
  logic [CHW-1:0] tag1_q;
  logic           s2Vld_q;
  logic [CHW-1:0] tag2_q;
  logic           rspValid_q;
  logic [CHW-1:0] rspChan_q;
  logic           rspOk_q;
  logic [CW-1:0]  cnt_q [NCH];
  logic [CW-1:0]  cnt_d [NCH];

  logic           grantEn;
  logic           found;
  logic           accept;
  logic [CHW-1:0] gntIdx;
  logic [DW-1:0]  gntData;
  logic           gntMode;
  logic           pipeEmpty;
  int             base;

  assign grantEn   = (state_q == RUN) && en;
  assign pipeEmpty = !chkValid_q && !s2Vld_q && !rspValid_q;
  assign accept    = |(req_valid & req_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (!en) state_d = DRAIN;
      DRAIN:   if (en) state_d = RUN;
               else if (pipeEmpty) state_d = HALT;
      HALT:    if (en) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Until the first grant after reset the search starts at channel 0.
  always_comb begin
    req_ready = '0;
    gntIdx    = '0;
    found     = 1'b0;
    base      = lastVld_q ? int'(rrPtr_q) : NCH - 1;
    if (grantEn) begin
      for (int i = 1; i <= NCH; i++) begin
        for (int j = 0; j < NCH; j++) begin
          if (!found && j == (base + i) % NCH && req_valid[j]) begin
            found        = 1'b1;
            gntIdx       = CHW'(j);
            req_ready[j] = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    gntData = '0;
    gntMode = 1'b0;
    for (int j = 0; j < NCH; j++) begin
      if (gntIdx == CHW'(j)) begin
        gntData = req_data[j*DW +: DW];
        gntMode = mode_cfg[j];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rrPtr_q    <= '0;
      lastVld_q  <= 1'b0;
      chkValid_q <= 1'b0;
      chkData_q  <= '0;
      chkMode_q  <= 1'b0;
      tag1_q     <= '0;
      s2Vld_q    <= 1'b0;
      tag2_q     <= '0;
      rspValid_q <= 1'b0;
      rspChan_q  <= '0;
      rspOk_q    <= 1'b0;
    end else begin
      chkValid_q <= accept;
      if (accept) begin
        chkData_q <= gntData;
        chkMode_q <= gntMode;
        tag1_q    <= gntIdx;
        rrPtr_q   <= gntIdx;
        lastVld_q <= 1'b1;
      end
      s2Vld_q    <= chkValid_q;
      tag2_q     <= tag1_q;
      rspValid_q <= s2Vld_q;
      rspChan_q  <= s2Vld_q ? tag2_q : '0;
      rspOk_q    <= s2Vld_q & chk_parity_ok;
    end
  end

  // A clear of the selected channel overrides a same-cycle increment.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NCH; i++) begin
      if (cnt_clr && cnt_sel == CHW'(i))
        cnt_d[i] = '0;
      else if (rspValid_q && !rspOk_q && rspChan_q == CHW'(i) && cnt_q[i] != '1)
        cnt_d[i] = cnt_q[i] + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    err_cnt = '0;
    for (int i = 0; i < NCH; i++)
      if (cnt_sel == CHW'(i)) err_cnt = cnt_q[i];
  end

`ifdef PARCTL_STICKY_ERR_EN
  logic [NCH-1:0] flag_q, flag_d;

  always_comb begin
    flag_d = flag_q;
    for (int i = 0; i < NCH; i++) begin
      if (cnt_clr && cnt_sel == CHW'(i))
        flag_d[i] = 1'b0;
      else if (rspValid_q && !rspOk_q && rspChan_q == CHW'(i))
        flag_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) flag_q <= '0;
    else     flag_q <= flag_d;
  end

  assign err_flag = flag_q;
  assign err_irq  = |flag_q;
`endif

  assign chk_valid = chkValid_q;
  assign chk_data  = chkData_q;
  assign chk_mode  = chkMode_q;
  assign rsp_valid = rspValid_q;
  assign rsp_chan  = rspChan_q;
  assign rsp_ok    = rspOk_q;
  assign idle      = (state_q == HALT);

endmodule

// File: tb/tb_parity_check_sched.sv
// Scoreboard bench for parity_check_sched: directed vectors, expected responses
// queued at issue time and popped by an independent response monitor.
module tb_parity_check_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic [3:0]  reqValid = '0;
  logic [11:0] reqData = '0;
  logic [3:0]  modeCfg = '0;
  logic [1:0]  cntSel = '0;
  logic        cntClr = 1'b0;
  logic        chkOk;
  logic [3:0]  req_ready;
  logic        chk_valid;
  logic [2:0]  chk_data;
  logic        chk_mode;
  logic        rsp_valid;
  logic [1:0]  rsp_chan;
  logic        rsp_ok;
  logic [7:0]  err_cnt;
  logic        idle;
`ifdef PARCTL_STICKY_ERR_EN
  logic [3:0]  err_flag;
  logic        err_irq;
`endif

  typedef struct {int chan; int ok; int cycle;} expT;
  expT sbQ[$];
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  logic okTab [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

  parity_check_sched #(.NCH(4), .DW(3), .CW(8)) dut (
    .clk(clk), .rst(rst), .en(enable),
    .req_valid(reqValid), .req_data(reqData), .req_ready(req_ready),
    .mode_cfg(modeCfg),
    .chk_valid(chk_valid), .chk_data(chk_data), .chk_mode(chk_mode),
    .chk_parity_ok(chkOk),
    .rsp_valid(rsp_valid), .rsp_chan(rsp_chan), .rsp_ok(rsp_ok),
    .cnt_sel(cntSel), .cnt_clr(cntClr), .err_cnt(err_cnt),
`ifdef PARCTL_STICKY_ERR_EN
    .err_flag(err_flag), .err_irq(err_irq),
`endif
    .idle(idle)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // External checker model: result registered one cycle after chk_valid.
  always @(posedge clk or posedge rst) begin
    if (rst) chkOk <= 1'b0;
    else     chkOk <= chk_valid && ((^chk_data) == chk_mode);
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int oneHotIdx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  always @(negedge clk) begin
    if (rsp_valid) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_rsp_valid", 1, 0);
      end else begin
        expT e;
        e = sbQ.pop_front();
        checkOutput("rsp_chan", int'(rsp_chan), e.chan);
        checkOutput("rsp_ok", int'(rsp_ok), e.ok);
        checkOutput("rsp_cycle", cyc, e.cycle);
      end
    end
  end

  task automatic applyStimulus(input logic enV, input logic [3:0] vld,
                               input logic [3:0] expReady, input logic expOk,
                               input bit track);
    @(negedge clk);
    enable   = enV;
    reqValid = vld;
    #1;
    checkOutput("req_ready", int'(req_ready), int'(expReady));
    if (track && expReady != 4'b0)
      sbQ.push_back('{chan: oneHotIdx(expReady), ok: int'(expOk), cycle: cyc + 3});
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(enable, 4'b0, 4'b0, 1'b0, 1'b1);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst      = 1'b1;
    reqValid = '0;
    cntClr   = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    checkOutput("reset_chk_valid", int'(chk_valid), 0);
    checkOutput("reset_chk_data", int'(chk_data), 0);
    checkOutput("reset_rsp_valid", int'(rsp_valid), 0);
    checkOutput("reset_rsp_chan", int'(rsp_chan), 0);
    checkOutput("reset_req_ready", int'(req_ready), 0);
    checkOutput("reset_idle", int'(idle), 0);
    checkOutput("reset_err_cnt", int'(err_cnt), 0);
    rst = 1'b0;

    // Single word on channel 0, even parity, good data.
    reqData = 12'b000_000_000_011;
    modeCfg = 4'b0000;
    applyStimulus(1'b1, 4'b0001, 4'b0001, 1'b1, 1'b1);
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1);
    checkOutput("chk_valid", int'(chk_valid), 1);
    checkOutput("chk_data", int'(chk_data), 3);
    checkOutput("chk_mode", int'(chk_mode), 0);
    idleCycles(5);

    // All four channels contending: strict rotation 0,1,2,3.
    doReset();
    reqData = {3'b110, 3'b111, 3'b001, 3'b011};
    modeCfg = 4'b0100;
    for (int k = 0; k < 8; k++)
      applyStimulus(1'b1, 4'b1111, 4'(1 << (k % 4)), okTab[k % 4], 1'b1);
    idleCycles(5);
    cntSel = 2'd1;
    #1 checkOutput("err_cnt_ch1_two_fails", int'(err_cnt), 2);
    cntSel = 2'd0;
    #1 checkOutput("err_cnt_ch0_clean", int'(err_cnt), 0);

    // Channel 2 odd mode with all-zero data: saturate, clear, clear-vs-increment.
    doReset();
    reqData = 12'b000_000_000_000;
    modeCfg = 4'b0100;
    cntSel  = 2'd2;
    for (int k = 0; k < 300; k++)
      applyStimulus(1'b1, 4'b0100, 4'b0100, 1'b0, 1'b1);
    idleCycles(5);
    checkOutput("err_cnt_saturated", int'(err_cnt), 255);
    @(negedge clk) cntClr = 1'b1;
    @(negedge clk) cntClr = 1'b0;
    #1 checkOutput("err_cnt_cleared", int'(err_cnt), 0);
    applyStimulus(1'b1, 4'b0100, 4'b0100, 1'b0, 1'b1);
    idleCycles(5);
    checkOutput("err_cnt_one", int'(err_cnt), 1);
    applyStimulus(1'b1, 4'b0100, 4'b0100, 1'b0, 1'b1);
    idleCycles(3);
    cntClr = 1'b1;
    idleCycles(1);
    cntClr = 1'b0;
    checkOutput("clear_beats_increment", int'(err_cnt), 0);
    idleCycles(3);
    checkOutput("clear_beats_increment_hold", int'(err_cnt), 0);

    // Drain and halt with two words in flight, then resume.
    doReset();
    reqData = 12'b011_011_011_011;
    modeCfg = 4'b0000;
    applyStimulus(1'b1, 4'b0011, 4'b0001, 1'b1, 1'b1);
    applyStimulus(1'b1, 4'b0010, 4'b0010, 1'b1, 1'b1);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 4'b1111, 4'b0000, 1'b0, 1'b1);
      checkOutput("drain_idle_low", int'(idle), 0);
    end
    applyStimulus(1'b0, 4'b1111, 4'b0000, 1'b0, 1'b1);
    checkOutput("halt_idle_high", int'(idle), 1);
    applyStimulus(1'b1, 4'b1111, 4'b0000, 1'b0, 1'b1);
    checkOutput("halt_exit_cycle_idle", int'(idle), 1);
    applyStimulus(1'b1, 4'b1111, 4'b0100, 1'b1, 1'b1);
    checkOutput("resumed_idle_low", int'(idle), 0);
    idleCycles(6);

    // Reset one cycle after an accept discards the in-flight word.
    reqData = 12'b000_000_001_000;
    applyStimulus(1'b1, 4'b0010, 4'b0010, 1'b0, 1'b0);
    @(negedge clk);
    reqValid = '0;
    rst = 1'b1;
    #1 checkOutput("reset_midflight_chk_valid", int'(chk_valid), 0);
    @(negedge clk) rst = 1'b0;
    idleCycles(5);
    cntSel = 2'd1;
    #1 checkOutput("reset_midflight_err_cnt", int'(err_cnt), 0);
    reqData = 12'b011_011_011_011;
    applyStimulus(1'b1, 4'b1010, 4'b0010, 1'b1, 1'b1);
    idleCycles(6);

`ifdef PARCTL_STICKY_ERR_EN
    doReset();
    reqData = 12'b000_000_001_000;
    modeCfg = 4'b0000;
    applyStimulus(1'b1, 4'b0010, 4'b0010, 1'b0, 1'b1);
    idleCycles(5);
    checkOutput("err_flag_set", int'(err_flag), 2);
    checkOutput("err_irq_set", int'(err_irq), 1);
    idleCycles(3);
    checkOutput("err_flag_held", int'(err_flag), 2);
    cntSel = 2'd1;
    @(negedge clk) cntClr = 1'b1;
    @(negedge clk) cntClr = 1'b0;
    #1;
    checkOutput("err_flag_cleared", int'(err_flag), 0);
    checkOutput("err_irq_cleared", int'(err_irq), 0);
`endif

    idleCycles(4);
    checkOutput("scoreboard_empty", sbQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/parity_check_sched.md
Name: parity_check_sched

Overview:
- Round-robin scheduler that shares one external parity checker among NCH requester channels.
- Each channel has its own parity mode: 0 = even, 1 = odd.
- Per granted word it drives the checker's data/mode/valid, tags the in-flight channel, and returns a response carrying the channel id.
- Keeps per-channel saturating error counters; sits between the link front-ends and the parity checker.

Parameters:
- NCH, 4, number of requester channels (2..8).
- DW, 3, data width per word; matches the checker data width.
- CW, 8, width of each per-channel error counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  scheduler enable; low requests a drain-and-halt.
- req_valid  in  NCH  per-channel request valid.
- req_data  in  NCH*DW  per-channel data; channel i occupies bits [i*DW +: DW].
- req_ready  out  NCH  per-channel accept; one-hot or zero.
- mode_cfg  in  NCH  per-channel parity mode (0 even, 1 odd).
- chk_valid  out  1  valid to checker.
- chk_data  out  DW  data to checker.
- chk_mode  out  1  mode to checker.
- chk_parity_ok  in  1  checker result, registered one cycle after chk_valid.
- rsp_valid  out  1  response valid, one-cycle pulse.
- rsp_chan  out  $clog2(NCH)  channel of response.
- rsp_ok  out  1  parity result for response.
- cnt_sel  in  $clog2(NCH)  error counter read/clear select.
- cnt_clr  in  1  clear selected counter.
- err_cnt  out  CW  error count of channel cnt_sel (combinational read).
- idle  out  1  high in HALT state.

Behaviour:
- Reset values:
  - All outputs 0 except idle = 0, because state resets to RUN.
  - Round-robin pointer = 0, so channel 0 has highest priority.
  - Pipeline valid bits = 0; counters = 0.
- States:
  - RUN: grants allowed.
  - DRAIN: no grants; in-flight words complete.
  - HALT: idle = 1, no grants.
- Transitions:
  - RUN -> DRAIN when en = 0.
  - DRAIN -> HALT when all three pipeline stages are empty.
  - DRAIN -> RUN if en returns to 1 before HALT is reached.
  - HALT -> RUN when en = 1; grants resume the next cycle.
- Arbitration (RUN only, combinational):
  - The first requesting channel after the last granted one, searching upward with wrap, wins.
  - req_ready[g] = 1 for the winner; acceptance = req_valid & req_ready.
  - Pointer updates to g on acceptance only; no grant means the pointer holds.
  - A single requester is granted every cycle (full throughput, one word per cycle).
- Requester rule: req_data must stay stable while req_valid = 1 and req_ready = 0; the scheduler never drops a held request.
- Pipeline (accept in cycle C):
  - Edge ending C: chk_data and chk_mode (= mode_cfg[g] sampled in C) register; chk_valid = 1 in C+1; stage-1 tag = g.
  - Checker result is present on chk_parity_ok in C+2; tag moves to stage 2.
  - Edge ending C+2: rsp_ok = chk_parity_ok, rsp_chan = tag, rsp_valid = 1 in C+3.
  - Fixed latency: accept to rsp_valid = 3 cycles.
  - chk_valid = 0 in any cycle with no accept in the previous cycle. chk_parity_ok is ignored when no stage-2 tag is valid.
  - There is no response backpressure; the consumer must accept every pulse.
- Error counters:
  - On rsp_valid with rsp_ok = 0, counter[rsp_chan] increments and saturates at 2^CW-1.
  - cnt_clr zeroes counter[cnt_sel]. If a clear and an increment hit the same channel in the same cycle, the clear wins (result 0).
- mode_cfg changes take effect at the next grant; words already in flight keep their captured mode.
- Reset mid-operation: all in-flight words are discarded and no response is emitted for them; state returns to RUN with pointer 0.

Optional Feature:
- Macro: PARCTL_STICKY_ERR_EN.
- When defined, adds:
  - Output err_flag (NCH): a per-channel sticky bit set on any failed response.
  - Output err_irq = OR of err_flag.
  - err_flag[cnt_sel] is cleared by cnt_clr, with the same clear-wins rule as the counters.
- When undefined, neither port exists and there is no flag logic.

Test Plan:
- NCH=4, DW=3. ch0 valid with data 3'b011, mode_cfg[0]=0 -> req_ready[0] in the same cycle; chk_valid/chk_data=3'b011/chk_mode=0 one cycle later; rsp_valid with rsp_chan=0, rsp_ok=1 three cycles after accept.
- All four channels valid continuously for 8 cycles -> grant order 0,1,2,3,0,1,2,3; rsp_chan follows the same sequence three cycles later, one response per cycle.
- ch2 mode_cfg=1, data 3'b000 sent 300 times -> every rsp_ok=0; with cnt_sel=2, err_cnt=255 (saturated); cnt_clr then err_cnt=0. Clear and increment in the same cycle -> 0.
- Two words in flight, then en=0 -> both responses emitted, no new grants, idle=1 after the pipeline empties; en=1 -> a grant occurs the cycle after leaving HALT.
- rst pulsed one cycle after an accept -> no rsp_valid for that word; counters 0; next grant goes to the lowest requesting channel from 0.
- With PARCTL_STICKY_ERR_EN defined: a single failing word on ch1 -> err_flag=4'b0010 and err_irq=1 held until cnt_sel=1 with cnt_clr.
